// File: rtl/hdr_serializer_nto1.sv
// rtl/hdr_serializer_nto1.sv - wide header word to narrow slice serializer
`timescale 1ns/1ps
module hdr_serializer_nto1 #(
  parameter int W_IN   = 128,
  parameter int W_OUT  = 32,
  parameter int W_ID   = 8,
  parameter int NSLICE = W_IN / W_OUT,
  parameter int CNTW   = $clog2(NSLICE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        fifo_empty,
  output logic                        rdreq,
  input  logic [W_ID+CNTW+W_IN:0]     data_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [W_OUT-1:0]            out_data,
  output logic                        out_last,
  output logic [W_ID-1:0]             out_id,
  output logic                        hdr_done,
  output logic [W_ID-1:0]             hdr_id
);

  localparam logic [0:0] STATE_EMPTY = 1'b0;
  localparam logic [0:0] STATE_BUSY  = 1'b1;
  localparam logic [CNTW-1:0] ONE = 1;

  logic [W_IN-1:0]  in_payload;
  logic [CNTW-1:0]  in_nvalid;
  logic             in_last;
  logic [W_ID-1:0]  in_id;

  assign in_payload = data_in[W_IN-1:0];
  assign in_nvalid  = data_in[W_IN+CNTW-1:W_IN];
  assign in_last    = data_in[W_IN+CNTW];
  assign in_id      = data_in[W_ID+CNTW+W_IN -: W_ID];

  logic [0:0]       state;
  logic [W_IN-1:0]  word_reg;
  logic             last_reg;
  logic [CNTW-1:0]  nm1_reg;
  logic [CNTW-1:0]  idx;
  logic [CNTW-1:0]  idx_nx;
  logic             accept;
  logic             final_slice;
  logic             load;

  logic [W_OUT-1:0] slice [NSLICE];

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    assign slice[g] = word_reg[W_IN-1-g*W_OUT -: W_OUT];
  end

  assign out_valid   = (state == STATE_BUSY);
  assign accept      = out_valid & out_ready;
  assign final_slice = (idx == nm1_reg);
  assign idx_nx      = idx + ONE;
  assign load        = enable & ~fifo_empty &
                       ((state == STATE_EMPTY) | (accept & final_slice));
  // Gated so no pop is issued while the block is held in reset.
  assign rdreq       = load & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= STATE_EMPTY;
      word_reg <= '0;
      last_reg <= 1'b0;
      nm1_reg  <= '0;
      idx      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      out_id   <= '0;
      hdr_done <= 1'b0;
      hdr_id   <= '0;
    end else begin
      hdr_done <= accept & out_last;
      if (accept & out_last) begin
        hdr_id <= out_id;
      end
      if (load) begin
        word_reg <= in_payload;
        last_reg <= in_last;
        // nvalid==0 wraps to NSLICE-1, i.e. a full word
        nm1_reg  <= in_nvalid - ONE;
        idx      <= '0;
        out_data <= in_payload[W_IN-1 -: W_OUT];
        out_id   <= in_id;
        out_last <= in_last & (in_nvalid == ONE);
        state    <= STATE_BUSY;
      end else if (accept) begin
        if (!final_slice) begin
          idx      <= idx_nx;
          out_data <= slice[idx_nx];
          out_last <= last_reg & (idx_nx == nm1_reg);
        end else begin
          out_last <= 1'b0;
          state    <= STATE_EMPTY;
        end
      end
    end
  end

endmodule

// File: doc/hdr_serializer_nto1.md
Name: hdr_serializer_nto1

Overview:
- Parametrised successor to the fixed 128-to-32 header distributor stage.
- Pops wide header words from a show-ahead FIFO and emits them as narrow slices, most significant slice first.
- Adds over the fixed version: per-word valid-slice count, valid/ready backpressure, zero-bubble back-to-back word loading, per-beat last/ID tagging and an end-of-header done pulse.
- Sits between the parser header FIFO and the extractor lanes.

Parameters:
- W_IN, 128: payload width of one FIFO word.
- W_OUT, 32: output slice width; W_IN must be an integer multiple of W_OUT.
- W_ID, 8: packet ID field width.
- NSLICE, W_IN/W_OUT: slices per word (derived; must be a power of two, at least 2).
- CNTW, clog2(NSLICE): width of the valid-slice count field.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset.
- enable, in, 1: permission to load new words from the FIFO.
- fifo_empty, in, 1: header FIFO empty flag.
- rdreq, out, 1: FIFO pop. Combinational; high exactly in cycles where a word is captured.
- data_in, in, W_ID+1+CNTW+W_IN: show-ahead word {id, last, nvalid, payload}. Valid whenever fifo_empty=0.
- out_valid, out, 1: out_data, out_last and out_id are valid.
- out_ready, in, 1: downstream accepts the current slice.
- out_data, out, W_OUT: current slice.
- out_last, out, 1: final slice of a word whose last flag is set.
- out_id, out, W_ID: ID of the word being emitted.
- hdr_done, out, 1: one-cycle pulse when a beat with out_last=1 is accepted.
- hdr_id, out, W_ID: ID captured with hdr_done; holds until the next done pulse.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, out_id=0, hdr_done=0, hdr_id=0, slice index=0, buffered word cleared. rdreq=0 while reset is asserted.
- nvalid field: value 0 means NSLICE slices; otherwise it is the slice count. Slice k covers payload[W_IN-1-k*W_OUT -: W_OUT].
- Two states:
  - EMPTY: out_valid=0.
  - BUSY: out_valid=1; word register, slice index idx and count n are held.
- Accept event: out_valid & out_ready. While out_ready=0, out_data, out_last and out_id hold stable.
- Load condition: enable & !fifo_empty & (state==EMPTY | (accept & idx==n-1)). rdreq = load condition.
- On load, at the clock edge:
  - capture the word; out_data <= slice 0; idx <= 0; out_valid <= 1; out_id <= id;
  - out_last <= last & (n==1); state <= BUSY.
- Accept with idx<n-1: idx <= idx+1; out_data <= slice idx+1; out_last <= last & (idx+1==n-1).
- Accept with idx==n-1 and no load: out_valid <= 0, out_last <= 0, state <= EMPTY. out_data holds its last value.
- Latency: first slice valid the cycle after the rdreq cycle.
- Throughput: one slice per cycle with no bubble between consecutive words while out_ready=1 and the FIFO is non-empty.
- hdr_done is registered: it pulses in the cycle after an accept with out_last=1, and hdr_id <= out_id on that same edge.
- enable deasserted mid-word: the current word drains completely and no further load occurs. enable has no effect on an in-progress word.
- fifo_empty rising while BUSY: no effect until the next load decision.
- Simultaneous final-slice accept and load: the new word's slice 0 replaces the old final slice on the same edge; out_valid stays 1.
- Reset mid-word: the buffered word is discarded and outputs return to reset values. The FIFO word already popped is not re-read.

Test Plan:
- Single word, id=8'h2A, last=1, nvalid=0, payload 0x11111111_22222222_33333333_44444444, out_ready=1:
  - rdreq for one cycle;
  - 4 beats 0x11111111 → 0x44444444; out_last only on beat 4;
  - hdr_done pulse the next cycle with hdr_id=0x2A.
- Two words queued, out_ready=1:
  - 8 consecutive valid beats with no gap;
  - rdreq in cycle 0 and again in cycle 4;
  - out_id switches on beat 5.
- nvalid=2, last=1: exactly 2 beats (slices 0 and 1); out_last on beat 2; slices 2–3 never appear.
- out_ready low for 3 cycles on beat 2: out_data remains 0x22222222 with out_valid=1; no rdreq; the beat sequence resumes intact.
- enable dropped after beat 1, FIFO non-empty: remaining 3 beats complete, then out_valid=0 and rdreq stays 0 until enable returns.
- reset asserted on beat 3: all outputs go to 0 immediately. After release, the next FIFO word emits from slice 0 and no hdr_done is produced for the aborted word.
